execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Y86-64 pipeline execute stage: E pipeline register (stall/bubble), ALU, condition-code
//  register and condition evaluation. Sits between decode (d_* outputs) and the memory
//  stage; e_valE_o/e_dstE_o also feed decode forwarding, e_cnd_o feeds memory (mispredict).
// PARAMETERS
//  XLEN      64     datapath width (fixed at 64 for Y86-64; kept for bench scaling)
//  CC_RESET  3'b100 reset value of {ZF,SF,OF}
// PORTS
//  clk_i      in   1     clock, rising edge
//  rst_i      in   1     synchronous reset, active-high
//  E_stall_i  in   1     hold E register
//  E_bubble_i in   1     load NOP bubble into E register
//  d_stat_i   in   3     decode stat      | d_icode_i in 4 | d_ifun_i in 4
//  d_valC_i   in   64    constant         | d_valA_i in 64 | d_valB_i in 64 (forwarded)
//  d_dstE_i   in   4     | d_dstM_i in 4  | d_srcA_i in 4  | d_srcB_i in 4
//  m_stat_i   in   3     stat of instr in memory stage (blocks CC update)
//  W_stat_i   in   3     stat of instr in writeback (blocks CC update)
//  E_icode_o  out  4     | E_stat_o out 3 | E_valA_o out 64 | E_dstM_o out 4 (registered)
//  E_srcA_o / E_srcB_o out 4 registered, for load-use hazard detection
//  e_valE_o   out  64    ALU result (combinational from E reg)
//  e_dstE_o   out  4     E_dstE, forced to RNONE(4'hF) on untaken cmov
//  e_cnd_o    out  1     condition result for JXX/CMOVXX
//  cc_o       out  3     current {ZF,SF,OF}, debug
// BEHAVIOUR
//  Clock/reset: one clock clk_i; reset rst_i synchronous active-high.
//  - Reset (next edge with rst_i=1): E reg = bubble: icode NOP(1), ifun 0, stat AOK(1),
//    valA/valB/valC 0, dstE/dstM/srcA/srcB RNONE; CC = CC_RESET. rst_i beats stall/bubble.
//  - Edge priority: rst_i > E_bubble_i > E_stall_i > load d_*. stall+bubble together is
//    illegal (bench asserts); RTL resolves to bubble.
//  - Latency: d_* -> E_* outputs 1 cycle; e_* combinational from E reg and CC, 0 cycles.
//  - aluA: valA for RRMOVQ(2)/OPQ(6); valC for IRMOVQ(3)/RMMOVQ(4)/MRMOVQ(5);
//    -8 for CALL(8)/PUSHQ(A); +8 for RET(9)/POPQ(B); else 0.
//  - aluB: valB for RMMOVQ/MRMOVQ/OPQ/CALL/RET/PUSHQ/POPQ; 0 for RRMOVQ/IRMOVQ; else 0.
//  - alufun = ifun when icode==OPQ, else ADD. ADD 0: B+A; SUB 1: B-A; AND 2: B&A;
//    XOR 3: B^A; ifun>3 on OPQ gives 0 (decode already flags INS). Mod-2^64 wrap.
//  - Flags: ZF=(res==0); SF=res[63]; OF add=(A[63]==B[63])&&(res[63]!=A[63]);
//    OF sub=(A[63]!=B[63])&&(res[63]!=B[63]); AND/XOR OF=0.
//  - set_cc = (E_icode==OPQ) && m_stat_i==AOK && W_stat_i==AOK && !E_stall_i;
//    CC loads at edge when set_cc; otherwise holds. Exception downstream never changes CC.
//  - cond(ifun, CC): 0 always; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF;
//    5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; 7..F -> 0. Uses CC before this instr's update.
//  - e_cnd_o = cond for JXX/RRMOVQ, 0 for all other icodes.
//  - e_dstE_o = RNONE when E_icode==RRMOVQ && !e_cnd_o, else E_dstE.
//  - Stat passes through unchanged; a bubble carries stat AOK and never sets CC.
// STRUCTURE
//  - Shared `include y86_defines.vh: ICODE_* (0..B), ALU_ADD/SUB/AND/XOR, C_* cond codes,
//    STAT_AOK/HLT/ADR/INS (1..4), RNONE 4'hF. No literals in RTL body.
//  - One sub-module: execute_alu (combinational: aluA, aluB, alufun -> res, zf, sf, of).
//  - execute_stage holds E register, CC register, operand muxes, cond logic.
// TESTING
//  - Reset: rst_i=1 one edge -> E_icode_o=1, e_dstE_o=F, e_valE_o=0, cc_o=100.
//  - OPQ add: valA=7FFF_FFFF_FFFF_FFFF, valB=1, ifun 0 -> e_valE_o=8000_0000_0000_0000,
//    next edge cc_o=011 (SF,OF).
//  - OPQ sub with m_stat_i=ADR(3): valA=5, valB=5 -> e_valE_o=0, cc_o unchanged.
//  - CMOVLE after sub 3-5 (SF=1): e_cnd_o=1, e_dstE_o=dstE; CMOVG -> e_dstE_o=F, valE=valA.
//  - PUSHQ valB=0x100 -> e_valE_o=0xF8; POPQ valB=0x100 -> 0x108; IRMOVQ valC=-1 -> -1.
//  - Stall 2 cycles while d_* changes -> E_* held; bubble -> E_icode_o=1, no CC change.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared Y86-64 encodings (icodes, ALU functions, condition codes, status) and
// the condition evaluator used by the execute stage.
package execute_stage_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    function automatic logic cond_eval(input logic [3:0] ifun, input cc_t cc);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (ifun)
            C_YES:   return 1'b1;
            C_LE:    return lt | cc.zf;
            C_L:     return lt;
            C_E:     return cc.zf;
            C_NE:    return !cc.zf;
            C_GE:    return !lt;
            C_G:     return !lt && !cc.zf;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute bundle plus the execute-stage results seen by decode and memory.
interface execute_stage_if #(parameter int XLEN = 64);

    logic            E_stall;
    logic            E_bubble;
    logic [2:0]      d_stat;
    logic [3:0]      d_icode;
    logic [3:0]      d_ifun;
    logic [XLEN-1:0] d_valC;
    logic [XLEN-1:0] d_valA;
    logic [XLEN-1:0] d_valB;
    logic [3:0]      d_dstE;
    logic [3:0]      d_dstM;
    logic [3:0]      d_srcA;
    logic [3:0]      d_srcB;
    logic [2:0]      m_stat;
    logic [2:0]      W_stat;

    logic [3:0]      E_icode;
    logic [2:0]      E_stat;
    logic [XLEN-1:0] E_valA;
    logic [3:0]      E_dstM;
    logic [3:0]      E_srcA;
    logic [3:0]      E_srcB;
    logic [XLEN-1:0] e_valE;
    logic [3:0]      e_dstE;
    logic            e_cnd;
    logic [2:0]      cc;

    modport master (
        output E_stall, E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat,
        input  E_icode, E_stat, E_valA, E_dstM, E_srcA, E_srcB, e_valE, e_dstE, e_cnd, cc
    );

    modport slave (
        input  E_stall, E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat,
        output E_icode, E_stat, E_valA, E_dstM, E_srcA, E_srcB, e_valE, e_dstE, e_cnd, cc
    );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational Y86-64 ALU: computes B op A and the {ZF,SF,OF} flags of the result.
module execute_stage_alu
    import execute_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic signed [XLEN-1:0] alu_a,
    input  logic signed [XLEN-1:0] alu_b,
    input  logic [3:0]             alufun,
    output logic signed [XLEN-1:0] res,
    output cc_t                    flags
);

    function automatic logic add_ovf(input logic signed [XLEN-1:0] a, b, r);
        return (a[XLEN-1] == b[XLEN-1]) && (r[XLEN-1] != a[XLEN-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [XLEN-1:0] a, b, r);
        return (a[XLEN-1] != b[XLEN-1]) && (r[XLEN-1] != b[XLEN-1]);
    endfunction

    logic ovf;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (alufun)
            ALU_ADD: begin
                res = alu_b + alu_a;
                ovf = add_ovf(alu_a, alu_b, alu_b + alu_a);
            end
            ALU_SUB: begin
                res = alu_b - alu_a;
                ovf = sub_ovf(alu_a, alu_b, alu_b - alu_a);
            end
            ALU_AND: res = alu_b & alu_a;
            ALU_XOR: res = alu_b ^ alu_a;
            // Undefined OPQ functions were already flagged INS by decode.
            default: res = '0;
        endcase
    end

    assign flags = '{zf: (res == '0), sf: res[XLEN-1], of: ovf};

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, operand selection, ALU, condition
// codes and branch/cmov condition.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int         XLEN     = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input logic            clk,
    input logic            rst,
    execute_stage_if.slave bus
);

    logic [3:0]             icode_p0, ifun_p0;
    logic [2:0]             stat_p0;
    logic signed [XLEN-1:0] val_a_p0, val_b_p0, val_c_p0;
    logic [3:0]             dst_e_p0, dst_m_p0, src_a_p0, src_b_p0;
    cc_t                    cc_p0;

    logic signed [XLEN-1:0] alu_a, alu_b, alu_res;
    logic [3:0]             alufun;
    cc_t                    alu_flags;
    logic                   set_cc, cnd;

    // Stage p0: E register; reset and bubble both insert a NOP.
    always_ff @(posedge clk) begin
        if (rst || bus.E_bubble) begin
            icode_p0 <= ICODE_NOP;
            ifun_p0  <= '0;
            stat_p0  <= STAT_AOK;
            val_a_p0 <= '0;
            val_b_p0 <= '0;
            val_c_p0 <= '0;
            dst_e_p0 <= RNONE;
            dst_m_p0 <= RNONE;
            src_a_p0 <= RNONE;
            src_b_p0 <= RNONE;
        end else if (!bus.E_stall) begin
            icode_p0 <= bus.d_icode;
            ifun_p0  <= bus.d_ifun;
            stat_p0  <= bus.d_stat;
            val_a_p0 <= $signed(bus.d_valA);
            val_b_p0 <= $signed(bus.d_valB);
            val_c_p0 <= $signed(bus.d_valC);
            dst_e_p0 <= bus.d_dstE;
            dst_m_p0 <= bus.d_dstM;
            src_a_p0 <= bus.d_srcA;
            src_b_p0 <= bus.d_srcB;
        end
    end

    // A downstream exception or a stalled E must leave CC untouched.
    assign set_cc = (icode_p0 == ICODE_OPQ) && (bus.m_stat == STAT_AOK) &&
                    (bus.W_stat == STAT_AOK) && !bus.E_stall;

    always_ff @(posedge clk) begin
        if (rst)
            cc_p0 <= CC_RESET;
        else if (set_cc)
            cc_p0 <= alu_flags;
    end

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (icode_p0)
            ICODE_RRMOVQ, ICODE_OPQ:                    alu_a = val_a_p0;
            ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:   alu_a = val_c_p0;
            ICODE_CALL, ICODE_PUSHQ:                    alu_a = -$signed(XLEN'(8));
            ICODE_RET, ICODE_POPQ:                      alu_a = $signed(XLEN'(8));
            default:                                    alu_a = '0;
        endcase
        case (icode_p0)
            ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_OPQ, ICODE_CALL,
            ICODE_RET, ICODE_PUSHQ, ICODE_POPQ:         alu_b = val_b_p0;
            default:                                    alu_b = '0;
        endcase
    end

    assign alufun = (icode_p0 == ICODE_OPQ) ? ifun_p0 : ALU_ADD;

    execute_stage_alu #(.XLEN(XLEN)) u_alu (
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alufun (alufun),
        .res    (alu_res),
        .flags  (alu_flags)
    );

    // Condition uses the CC as it stood before this instruction's own update.
    assign cnd = ((icode_p0 == ICODE_JXX) || (icode_p0 == ICODE_RRMOVQ)) &&
                 cond_eval(ifun_p0, cc_p0);

    assign bus.E_icode = icode_p0;
    assign bus.E_stat  = stat_p0;
    assign bus.E_valA  = val_a_p0;
    assign bus.E_dstM  = dst_m_p0;
    assign bus.E_srcA  = src_a_p0;
    assign bus.E_srcB  = src_b_p0;
    assign bus.e_valE  = alu_res;
    assign bus.e_cnd   = cnd;
    assign bus.e_dstE  = ((icode_p0 == ICODE_RRMOVQ) && !cnd) ? RNONE : dst_e_p0;
    assign bus.cc      = cc_p0;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, ALU ops, CC gating, conditions, stall/bubble.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_stage_if #(.XLEN(64)) bus();

    execute_stage #(.XLEN(64), .CC_RESET(3'b100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        assert (!(bus.E_stall && bus.E_bubble))
        else begin
            miscompares++;
            $error("FAIL stall_bubble observed=11 expected=not both");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] va, input logic [63:0] vb,
                        input logic [63:0] vc, input logic [3:0] dste);
        bus.d_stat  = STAT_AOK;
        bus.d_icode = icode;
        bus.d_ifun  = ifun;
        bus.d_valA  = va;
        bus.d_valB  = vb;
        bus.d_valC  = vc;
        bus.d_dstE  = dste;
        bus.d_dstM  = RNONE;
        bus.d_srcA  = RNONE;
        bus.d_srcB  = RNONE;
    endtask

    initial begin
        rst = 1'b1;
        bus.E_stall  = 1'b0;
        bus.E_bubble = 1'b0;
        bus.m_stat   = STAT_AOK;
        bus.W_stat   = STAT_AOK;
        load(ICODE_OPQ, ALU_ADD, 64'd1, 64'd2, 64'd3, 4'h4);
        step();
        check("rst_icode", 64'(bus.E_icode), 64'h1);
        check("rst_dstE", 64'(bus.e_dstE), 64'hF);
        check("rst_valE", bus.e_valE, 64'h0);
        check("rst_cc", 64'(bus.cc), 64'h4);
        check("rst_stat", 64'(bus.E_stat), 64'h1);

        // OPQ add overflowing into the sign bit
        rst = 1'b0;
        load(ICODE_OPQ, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h3);
        step();
        check("add_valE", bus.e_valE, 64'h8000_0000_0000_0000);
        check("add_cc_before", 64'(bus.cc), 64'h4);
        load(ICODE_NOP, 4'h0, 64'h0, 64'h0, 64'h0, RNONE);
        step();
        check("add_cc_after", 64'(bus.cc), 64'h3);

        // OPQ sub while memory stage holds an exception: CC must not move
        load(ICODE_OPQ, ALU_SUB, 64'd5, 64'd5, 64'h0, 4'h3);
        step();
        bus.m_stat = STAT_ADR;
        check("sub_adr_valE", bus.e_valE, 64'h0);
        load(ICODE_NOP, 4'h0, 64'h0, 64'h0, 64'h0, RNONE);
        step();
        check("sub_adr_cc", 64'(bus.cc), 64'h3);
        bus.m_stat = STAT_AOK;

        // 3 - 5 = -2 -> SF only
        load(ICODE_OPQ, ALU_SUB, 64'd5, 64'd3, 64'h0, 4'h3);
        step();
        check("sub_neg_valE", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        load(ICODE_RRMOVQ, C_LE, 64'h1234, 64'h0, 64'h0, 4'h5);
        step();
        check("sub_neg_cc", 64'(bus.cc), 64'h2);
        check("cmovle_cnd", 64'(bus.e_cnd), 64'h1);
        check("cmovle_dstE", 64'(bus.e_dstE), 64'h5);
        check("cmovle_valE", bus.e_valE, 64'h1234);
        load(ICODE_RRMOVQ, C_G, 64'h55, 64'h0, 64'h0, 4'h5);
        step();
        check("cmovg_cnd", 64'(bus.e_cnd), 64'h0);
        check("cmovg_dstE", 64'(bus.e_dstE), 64'hF);
        check("cmovg_valE", bus.e_valE, 64'h55);
        check("cmovg_cc", 64'(bus.cc), 64'h2);

        load(ICODE_JXX, C_L, 64'h0, 64'h0, 64'h400, RNONE);
        step();
        check("jl_cnd", 64'(bus.e_cnd), 64'h1);
        load(ICODE_PUSHQ, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
        step();
        check("pushq_valE", bus.e_valE, 64'hF8);
        check("pushq_cnd", 64'(bus.e_cnd), 64'h0);
        load(ICODE_POPQ, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
        step();
        check("popq_valE", bus.e_valE, 64'h108);
        load(ICODE_IRMOVQ, 4'h0, 64'h0, 64'h77, 64'hFFFF_FFFF_FFFF_FFFF, 4'h2);
        step();
        check("irmovq_valE", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFFF);

        // XOR then stall two cycles while decode changes; stalled OPQ leaves CC alone
        load(ICODE_OPQ, ALU_XOR, 64'hF0, 64'hFF, 64'h0, 4'h2);
        step();
        check("xor_valE", bus.e_valE, 64'h0F);
        bus.E_stall = 1'b1;
        load(ICODE_RMMOVQ, 4'h0, 64'd999, 64'd888, 64'd777, 4'h6);
        step();
        load(ICODE_MRMOVQ, 4'h0, 64'd111, 64'd222, 64'd333, 4'h7);
        step();
        check("stall_icode", 64'(bus.E_icode), 64'h6);
        check("stall_valA", bus.E_valA, 64'hF0);
        check("stall_valE", bus.e_valE, 64'h0F);
        check("stall_cc", 64'(bus.cc), 64'h2);

        // Bubble: the XOR leaving E updates CC, the bubble itself never does
        bus.E_stall  = 1'b0;
        bus.E_bubble = 1'b1;
        step();
        check("bubble_icode", 64'(bus.E_icode), 64'h1);
        check("bubble_dstE", 64'(bus.e_dstE), 64'hF);
        check("bubble_cc_xor", 64'(bus.cc), 64'h0);
        step();
        check("bubble_cc_hold", 64'(bus.cc), 64'h0);
        bus.E_bubble = 1'b0;

        // Stat and register ids pass straight through
        load(ICODE_HALT, 4'h0, 64'h0, 64'h0, 64'h0, RNONE);
        bus.d_stat = STAT_HLT;
        bus.d_srcA = 4'h4;
        bus.d_srcB = 4'h5;
        bus.d_dstM = 4'h6;
        step();
        check("pass_stat", 64'(bus.E_stat), 64'h2);
        check("pass_icode", 64'(bus.E_icode), 64'h0);
        check("pass_srcA", 64'(bus.E_srcA), 64'h4);
        check("pass_srcB", 64'(bus.E_srcB), 64'h5);
        check("pass_dstM", 64'(bus.E_dstM), 64'h6);

        // Reset wins over stall
        bus.E_stall = 1'b1;
        rst = 1'b1;
        step();
        check("rst_stall_icode", 64'(bus.E_icode), 64'h1);
        check("rst_stall_srcA", 64'(bus.E_srcA), 64'hF);
        check("rst_stall_cc", 64'(bus.cc), 64'h4);
        rst = 1'b0;
        bus.E_stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
